// File: rtl/rf_dump_reader.sv
// Register-file dump master: walks FIRST_REG..LAST_REG two registers per fetch and streams beats.
// Define RF_DUMP_DISPLAY_EN to print every accepted beat and the end of the dump in simulation.
module rf_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_start,
    output logic        busy,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_reg,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        done
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND_A,
        S_SEND_B,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  ptr_nxt;

    // Partner register of the pair; wraps 31 -> 0, which only matters for a discarded B capture.
    assign ptr_nxt = ptr_q + 5'd1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= FIRST;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        busy      = 1'b0;
        rs_addr   = '0;
        rt_addr   = '0;
        out_valid = 1'b0;
        out_reg   = '0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_FETCH;
                    ptr_d   = FIRST;
                end
            end
            S_FETCH: begin
                busy    = 1'b1;
                rs_addr = ptr_q;
                rt_addr = ptr_nxt;
                // Both read ports are captured on the same edge: the pair is a coherent snapshot.
                a_d     = rs_data;
                b_d     = rt_data;
                state_d = S_SEND_A;
            end
            S_SEND_A: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_reg   = ptr_q;
                out_data  = a_q;
                out_last  = (ptr_q == LAST);
                if (out_ready) begin
                    state_d = (ptr_q == LAST) ? S_DONE : S_SEND_B;
                end
            end
            S_SEND_B: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_reg   = ptr_nxt;
                out_data  = b_q;
                out_last  = (ptr_nxt == LAST);
                if (out_ready) begin
                    if (ptr_nxt == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 5'd2;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef RF_DUMP_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                $display("dump $%d = %h", out_reg, out_data);
            end
            if (done) begin
                $display("dump end");
            end
        end
    end
`else
    // Silent build: no simulation output logic.
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: three instances (0..31, 3..7, 31..31) share a modelled RF.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start  [3];
    logic        ready  [3];
    logic        busy   [3];
    logic [4:0]  rs_a   [3];
    logic [4:0]  rt_a   [3];
    logic [31:0] rs_d   [3];
    logic [31:0] rt_d   [3];
    logic        valid  [3];
    logic [4:0]  oreg   [3];
    logic [31:0] odata  [3];
    logic        olast  [3];
    logic        done   [3];

    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    logic [4:0]  got_reg  [64];
    logic [31:0] got_data [64];
    logic        got_last [64];

    typedef struct {
        int inst;
        bit toggle;
        int first_r;
        int last_r;
        int done_cyc;
    } scen_t;

    scen_t scen [4];

    always #5 clk = ~clk;

    assign rs_d[0] = rf[rs_a[0]];
    assign rt_d[0] = rf[rt_a[0]];
    assign rs_d[1] = rf[rs_a[1]];
    assign rt_d[1] = rf[rt_a[1]];
    assign rs_d[2] = rf[rs_a[2]];
    assign rt_d[2] = rf[rt_a[2]];

    rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .reset(reset), .dump_start(start[0]), .busy(busy[0]),
        .rs_addr(rs_a[0]), .rt_addr(rt_a[0]), .rs_data(rs_d[0]), .rt_data(rt_d[0]),
        .out_valid(valid[0]), .out_ready(ready[0]), .out_reg(oreg[0]),
        .out_data(odata[0]), .out_last(olast[0]), .done(done[0])
    );

    rf_dump_reader #(.FIRST_REG(3), .LAST_REG(7)) u_mid (
        .clk(clk), .reset(reset), .dump_start(start[1]), .busy(busy[1]),
        .rs_addr(rs_a[1]), .rt_addr(rt_a[1]), .rs_data(rs_d[1]), .rt_data(rt_d[1]),
        .out_valid(valid[1]), .out_ready(ready[1]), .out_reg(oreg[1]),
        .out_data(odata[1]), .out_last(olast[1]), .done(done[1])
    );

    rf_dump_reader #(.FIRST_REG(31), .LAST_REG(31)) u_top (
        .clk(clk), .reset(reset), .dump_start(start[2]), .busy(busy[2]),
        .rs_addr(rs_a[2]), .rt_addr(rt_a[2]), .rs_data(rs_d[2]), .rt_data(rt_d[2]),
        .out_valid(valid[2]), .out_ready(ready[2]), .out_reg(oreg[2]),
        .out_data(odata[2]), .out_last(olast[2]), .done(done[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts a dump on instance k and records accepted beats until done or a cycle budget expires.
    // Cycle 0 is the first cycle after the edge that accepted dump_start (the FETCH cycle).
    task automatic run_dump(input int k, input bit toggle, input int xstart_cyc,
                            input int wr_cyc, input logic [4:0] wr_reg, input logic [31:0] wr_val,
                            output int nbeats, output int done_cyc,
                            output logic [4:0] rs0, output logic [4:0] rt0);
        bit          stalled;
        logic [4:0]  h_reg;
        logic [31:0] h_data;
        logic        h_last;
        nbeats   = 0;
        done_cyc = -1;
        stalled  = 1'b0;
        h_reg    = '0;
        h_data   = '0;
        h_last   = 1'b0;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        check("busy_after_start", 32'(busy[k]), 32'd1);
        rs0 = rs_a[k];
        rt0 = rt_a[k];
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start[k] = (cyc == xstart_cyc);
            if (cyc == wr_cyc) rf[wr_reg] = wr_val;
            ready[k] = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled) begin
                check("hold_valid", 32'(valid[k]), 32'd1);
                check("hold_reg",   32'(oreg[k]),  32'(h_reg));
                check("hold_data",  odata[k],      h_data);
                check("hold_last",  32'(olast[k]), 32'(h_last));
            end
            if (done[k]) begin
                done_cyc = cyc;
                check("busy_in_done",  32'(busy[k]),  32'd0);
                check("valid_in_done", 32'(valid[k]), 32'd0);
                break;
            end
            if (valid[k]) begin
                if (ready[k] && nbeats < 64) begin
                    got_reg[nbeats]  = oreg[k];
                    got_data[nbeats] = odata[k];
                    got_last[nbeats] = olast[k];
                    nbeats++;
                end
                stalled = !ready[k];
                h_reg   = oreg[k];
                h_data  = odata[k];
                h_last  = olast[k];
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk);
        end
        start[k] = 1'b0;
        ready[k] = 1'b0;
    endtask

    task automatic compare_beats(input int first_r, input int last_r, input int nbeats,
                                 input int done_cyc, input int exp_done,
                                 input logic [4:0] rs0, input logic [4:0] rt0);
        int n;
        n = last_r - first_r + 1;
        check("beat_count", 32'(nbeats), 32'(n));
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("fetch_rs_addr", 32'(rs0), 32'(first_r));
        check("fetch_rt_addr", 32'(rt0), 32'((first_r + 1) % 32));
        for (int i = 0; i < n && i < nbeats; i++) begin
            check("beat_reg",  32'(got_reg[i]),  32'(first_r + i));
            check("beat_data", got_data[i],      rf[first_r + i]);
            check("beat_last", 32'(got_last[i]), 32'(first_r + i == last_r));
        end
    endtask

    initial begin
        int          nb;
        int          dc;
        logic [4:0]  r0;
        logic [4:0]  t0;
        bit          found;

        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            ready[k] = 1'b0;
        end

        scen[0] = '{inst: 0, toggle: 1'b0, first_r: 0,  last_r: 31, done_cyc: 48};
        scen[1] = '{inst: 0, toggle: 1'b1, first_r: 0,  last_r: 31, done_cyc: 65};
        scen[2] = '{inst: 1, toggle: 1'b0, first_r: 3,  last_r: 7,  done_cyc: 8};
        scen[3] = '{inst: 2, toggle: 1'b0, first_r: 31, last_r: 31, done_cyc: 2};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy",  32'(busy[0]),  32'd0);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_done",  32'(done[0]),  32'd0);
        check("rst_last",  32'(olast[0]), 32'd0);
        check("rst_reg",   32'(oreg[0]),  32'd0);
        check("rst_data",  odata[0],      32'd0);
        check("rst_rs",    32'(rs_a[0]),  32'd0);
        check("rst_rt",    32'(rt_a[0]),  32'd0);

        for (int s = 0; s < 4; s++) begin
            run_dump(scen[s].inst, scen[s].toggle, -1, -1, 5'd0, 32'd0, nb, dc, r0, t0);
            compare_beats(scen[s].first_r, scen[s].last_r, nb, dc, scen[s].done_cyc, r0, t0);
            @(negedge clk);
            check("done_one_cycle", 32'(done[scen[s].inst]), 32'd0);
            repeat (2) @(negedge clk);
        end

        // Reset while SEND_B presents reg 9: aborts with no done pulse, restart begins at reg 0.
        @(negedge clk);
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid[0] && oreg[0] == 5'd9) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_reg9", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ready[0] = 1'b0;
        check("abort_valid", 32'(valid[0]), 32'd0);
        check("abort_busy",  32'(busy[0]),  32'd0);
        check("abort_done",  32'(done[0]),  32'd0);
        check("abort_rs",    32'(rs_a[0]),  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done[0]), 32'd0);
        end
        run_dump(0, 1'b0, -1, -1, 5'd0, 32'd0, nb, dc, r0, t0);
        compare_beats(0, 31, nb, dc, 48, r0, t0);
        repeat (2) @(negedge clk);

        // Second start while busy is ignored; RF write to reg 20 before its fetch is visible.
        run_dump(0, 1'b0, 3, 5, 5'd20, 32'hDEAD_BEEF, nb, dc, r0, t0);
        compare_beats(0, 31, nb, dc, 48, r0, t0);
        check("reg20_new", got_data[20], 32'hDEAD_BEEF);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("start_in_done_busy",  32'(busy[0]),  32'd0);
        check("start_in_done_valid", 32'(valid[0]), 32'd0);
        check("start_in_done_done",  32'(done[0]),  32'd0);
        @(negedge clk);
        check("start_in_done_idle", 32'(busy[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
